glitch_pulse_gen: RTL and testbench
===================================

Name: glitch_pulse_gen

Overview:
- Trigger-timed sequencer that produces the enable stream consumed by the glitch core's `en` input.
- Armed by control logic with a latched delay/width/gap/count configuration.
- Waits for an external trigger edge, then emits a programmable train of enable pulses, cycle-exact relative to the trigger.
- Sits between the host control registers and the glitch core; mode selection stays in the core.

Parameters:
- CNT_W, 16, width of delay/width/gap counters
- REP_W, 8, width of pulse-count field

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- arm  in  1  level; sampled only in IDLE; latches config and enters ARMED
- abort  in  1  synchronous cancel from any state
- trigger  in  1  external asynchronous trigger; rising edge starts the sequence
- delay  in  CNT_W  cycles from trigger edge detect to first pulse
- width  in  CNT_W  high cycles per pulse; 0 treated as 1
- gap  in  CNT_W  low cycles between pulses; 0 treated as 1
- count  in  REP_W  number of pulses; 0 treated as 1
- en_out  out  1  registered enable to glitch core
- armed  out  1  high in ARMED
- busy  out  1  high in DELAY, PULSE or GAP
- done  out  1  one-cycle pulse on normal completion
- pulse_idx  out  REP_W  index of the current or last pulse, 0-based

Behaviour:
- Reset (async assert, sync release):
  - state IDLE.
  - en_out, armed, busy, done = 0.
  - pulse_idx = 0.
  - All latched config = 0.
- Trigger path:
  - 2-FF synchronizer, then edge detect `edge = s2 & ~s3`.
  - Latency from the trigger pin to `edge` is 2–3 clk; this is documented jitter and is not compensated.
- States and transitions:
  - IDLE:
    - arm=1 and abort=0 → latch delay/width/gap/count (zero-substituted), clear pulse_idx, go to ARMED.
    - done=0.
  - ARMED:
    - edge=1 → DELAY with counter=delay, or directly to PULSE if delay==0.
    - Edges seen before entering ARMED are ignored.
  - DELAY: decrement each cycle; at counter==1 go to PULSE.
  - PULSE:
    - en_out=1 for exactly `width` cycles.
    - At the end: if pulse_idx==count-1 → IDLE with done=1 for one cycle; else → GAP.
  - GAP:
    - en_out=0 for exactly `gap` cycles.
    - Then increment pulse_idx and go to PULSE.
- Timing contract:
  - Edge true in cycle T → first en_out high in cycle T+1+delay.
  - Pulse k (0-based) rises at T+1+delay+k*(width+gap).
  - done is high in the cycle after the final en_out-high cycle; en_out=0 in that cycle.
- Outputs: en_out and busy are registered outputs decoded from next-state; no combinational path from any input to en_out.
- abort:
  - Any state → IDLE next cycle; en_out=0 next cycle; done not asserted; pulse_idx holds its value.
  - arm and abort in the same cycle → abort wins.
- Config and trigger while running:
  - Config inputs are ignored outside IDLE.
  - arm while not in IDLE is ignored.
  - Trigger edges while busy are ignored; no re-trigger and no queueing.
- Return to IDLE:
  - After done, the block does not re-arm automatically.
  - arm held high re-arms in the cycle after done.
- Counters:
  - Unsigned, CNT_W bits.
  - Maximum delay = 2^CNT_W-1 cycles.
  - No wrap is possible because counters load and count down to 1.
- Reset mid-sequence: en_out drops asynchronously at rst_n assertion; a glitch already in progress is truncated.

Decomposition:
- Shared defs file (glitch_defs.v):
  - state encodings PG_IDLE/PG_ARMED/PG_DELAY/PG_PULSE/PG_GAP (3-bit).
  - default CNT_W/REP_W macros.
- One natural sub-module: glitch_trig_sync (2-FF synchronizer plus rising-edge detect, async active-low reset, reset value 0).
- The FSM and down-counter stay in glitch_pulse_gen.

Test Plan:
- delay=5, width=3, gap=2, count=1; arm; trigger rises → en_out high exactly cycles T+6..T+8; done in T+9; busy low in T+9.
- delay=0, width=0, gap=0, count=3 → three single-cycle pulses at T+1, T+3, T+5; pulse_idx 0,1,2; one done pulse.
- delay=10, width=4, count=2; assert abort at T+7 → en_out never high; state IDLE at T+8; no done; armed=0, busy=0.
- Trigger pulse before arm, then arm with trigger held high → no start; a fresh low→high trigger starts the sequence; a second edge during PULSE is ignored (pulse count unchanged).
- Change width from 3 to 9 mid-sequence after arm → all pulses remain 3 cycles wide; arm and abort together in IDLE → stays IDLE.
- rst_n low during PULSE → en_out 0 immediately (asynchronous); after release all outputs at reset values; a new arm/trigger sequence then works normally.

Source files
------------

// File: rtl/glitch_pulse_gen_pkg.sv
// Shared definitions for the trigger-timed glitch enable sequencer:
// state encodings, default field widths and small decode helpers.
package glitch_pulse_gen_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int REP_W_DEF = 8;

    typedef enum logic [2:0] {
        PG_IDLE  = 3'd0,
        PG_ARMED = 3'd1,
        PG_DELAY = 3'd2,
        PG_PULSE = 3'd3,
        PG_GAP   = 3'd4
    } pg_state_e;

    function automatic logic is_busy(input pg_state_e s);
        return (s == PG_DELAY) || (s == PG_PULSE) || (s == PG_GAP);
    endfunction

endpackage

// File: rtl/glitch_trig_sync.sv
// Two-flop synchronizer for the asynchronous trigger pin followed by a
// rising-edge detector; the edge is a single-cycle strobe in the clk domain.
module glitch_trig_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic trigger,
    output logic trig_edge
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Synchronizer chain plus one history stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= trigger;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign trig_edge = s2_r & ~s3_r;

endmodule

// File: rtl/glitch_pulse_gen.sv
// Trigger-timed sequencer producing the enable stream for the glitch core:
// arm latches the config, a trigger edge starts delay then a train of pulses.
module glitch_pulse_gen
    import glitch_pulse_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int REP_W = REP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             abort,
    input  logic             trigger,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] gap,
    input  logic [REP_W-1:0] count,
    output logic             en_out,
    output logic             armed,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] pulse_idx
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};
    localparam logic [REP_W-1:0] REP_ONE  = {{(REP_W-1){1'b0}}, 1'b1};

    pg_state_e        state_r;
    pg_state_e        next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [CNT_W-1:0] delay_r;
    logic [CNT_W-1:0] width_r;
    logic [CNT_W-1:0] gap_r;
    logic [REP_W-1:0] count_r;
    logic [REP_W-1:0] pulse_idx_r;
    logic [REP_W-1:0] idx_next_s;
    logic             load_cfg_s;
    logic             done_next_s;
    logic             trig_edge_s;
    logic             en_r;
    logic             armed_r;
    logic             busy_r;
    logic             done_r;

    glitch_trig_sync u_trig_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .trigger   (trigger),
        .trig_edge (trig_edge_s)
    );

    // Next-state, counter reload and pulse index decode.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        idx_next_s   = pulse_idx_r;
        load_cfg_s   = 1'b0;
        done_next_s  = 1'b0;
        if (abort) begin
            next_state_s = PG_IDLE;
        end else begin
            case (state_r)
                PG_IDLE: begin
                    if (arm) begin
                        next_state_s = PG_ARMED;
                        load_cfg_s   = 1'b1;
                        idx_next_s   = REP_ZERO;
                    end else begin
                        next_state_s = PG_IDLE;
                    end
                end
                PG_ARMED: begin
                    if (trig_edge_s) begin
                        if (delay_r == CNT_ZERO) begin
                            next_state_s = PG_PULSE;
                            cnt_next_s   = width_r;
                        end else begin
                            next_state_s = PG_DELAY;
                            cnt_next_s   = delay_r;
                        end
                    end else begin
                        next_state_s = PG_ARMED;
                    end
                end
                PG_DELAY: begin
                    if (cnt_r == CNT_ONE) begin
                        next_state_s = PG_PULSE;
                        cnt_next_s   = width_r;
                    end else begin
                        cnt_next_s = cnt_r - CNT_ONE;
                    end
                end
                PG_PULSE: begin
                    if (cnt_r == CNT_ONE) begin
                        if (pulse_idx_r == (count_r - REP_ONE)) begin
                            next_state_s = PG_IDLE;
                            done_next_s  = 1'b1;
                        end else begin
                            next_state_s = PG_GAP;
                            cnt_next_s   = gap_r;
                        end
                    end else begin
                        cnt_next_s = cnt_r - CNT_ONE;
                    end
                end
                PG_GAP: begin
                    if (cnt_r == CNT_ONE) begin
                        next_state_s = PG_PULSE;
                        cnt_next_s   = width_r;
                        idx_next_s   = pulse_idx_r + REP_ONE;
                    end else begin
                        cnt_next_s = cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    next_state_s = PG_IDLE;
                end
            endcase
        end
    end

    // State, counter, index and outputs; outputs decode next-state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= PG_IDLE;
            cnt_r       <= CNT_ZERO;
            pulse_idx_r <= REP_ZERO;
            en_r        <= 1'b0;
            armed_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            cnt_r       <= cnt_next_s;
            pulse_idx_r <= idx_next_s;
            en_r        <= (next_state_s == PG_PULSE);
            armed_r     <= (next_state_s == PG_ARMED);
            busy_r      <= is_busy(next_state_s);
            done_r      <= done_next_s;
        end
    end

    // Configuration latch; zero width/gap/count are promoted to one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_r <= CNT_ZERO;
            width_r <= CNT_ZERO;
            gap_r   <= CNT_ZERO;
            count_r <= REP_ZERO;
        end else if (load_cfg_s) begin
            delay_r <= delay;
            width_r <= (width == CNT_ZERO) ? CNT_ONE : width;
            gap_r   <= (gap == CNT_ZERO) ? CNT_ONE : gap;
            count_r <= (count == REP_ZERO) ? REP_ONE : count;
        end
    end

    assign en_out    = en_r;
    assign armed     = armed_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pulse_idx = pulse_idx_r;

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Scoreboard bench for glitch_pulse_gen: stimulus pushes expected rise/fall/done
// events with their cycle numbers; an independent monitor pops and compares them.
module tb_glitch_pulse_gen;

    localparam int EV_RISE = 0;
    localparam int EV_FALL = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int kind;
        int cyc;
        int idx;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic        arm;
    logic        abort;
    logic        trigger;
    logic [15:0] delay;
    logic [15:0] width;
    logic [15:0] gap;
    logic [7:0]  count;
    logic        en_out;
    logic        armed;
    logic        busy;
    logic        done;
    logic [7:0]  pulse_idx;

    int  cyc;
    int  n_checks;
    int  n_errors;
    bit  prev_en;
    ev_t exp_q[$];

    glitch_pulse_gen #(.CNT_W(16), .REP_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm       (arm),
        .abort     (abort),
        .trigger   (trigger),
        .delay     (delay),
        .width     (width),
        .gap       (gap),
        .count     (count),
        .en_out    (en_out),
        .armed     (armed),
        .busy      (busy),
        .done      (done),
        .pulse_idx (pulse_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic see_event(input int kind);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d idx %0d, expected no event",
                     kind, cyc, pulse_idx);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.idx != int'(pulse_idx)) begin
                n_errors++;
                $display("FAIL event: got kind %0d cycle %0d idx %0d, expected kind %0d cycle %0d idx %0d",
                         kind, cyc, pulse_idx, e.kind, e.cyc, e.idx);
            end
        end
    endtask

    // Monitor: turns en_out edges and done pulses into events and scores them.
    initial begin
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_en = 1'b0;
            end else begin
                if (en_out && !prev_en) see_event(EV_RISE);
                if (!en_out && prev_en) see_event(EV_FALL);
                if (done) begin
                    see_event(EV_DONE);
                    chk("busy_at_done", int'(busy), 0);
                    chk("en_at_done", int'(en_out), 0);
                end
                prev_en = en_out;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    // Expected schedule: pulse k rises at t+1+d+k*(w+g), falls w cycles later.
    task automatic push_seq(input int t, input int d, input int w, input int g, input int n);
        int ww;
        int gg;
        int nn;
        int r;
        ww = (w == 0) ? 1 : w;
        gg = (g == 0) ? 1 : g;
        nn = (n == 0) ? 1 : n;
        for (int k = 0; k < nn; k++) begin
            r = t + 1 + d + k * (ww + gg);
            exp_q.push_back('{EV_RISE, r, k});
            exp_q.push_back('{EV_FALL, r + ww, k});
            if (k == nn - 1) exp_q.push_back('{EV_DONE, r + ww, k});
        end
    endtask

    task automatic arm_cfg(input int d, input int w, input int g, input int n);
        delay = 16'(d);
        width = 16'(w);
        gap   = 16'(g);
        count = 8'(n);
        arm   = 1'b1;
        tick();
        arm   = 1'b0;
        chk("armed_after_arm", int'(armed), 1);
        chk("busy_after_arm", int'(busy), 0);
    endtask

    // Raise trigger; edge is seen two cycles later (synchronizer).
    task automatic fire_seq(input int d, input int w, input int g, input int n, output int t);
        trigger = 1'b1;
        t = cyc + 2;
        push_seq(t, d, w, g, n);
        repeat (3) tick();
        trigger = 1'b0;
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        while (exp_q.size() > 0 && i < budget) begin
            tick();
            i++;
        end
        n_checks++;
        if (exp_q.size() > 0) begin
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending events expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    initial begin
        int t;
        n_checks = 0;
        n_errors = 0;
        rst_n   = 1'b0;
        arm     = 1'b0;
        abort   = 1'b0;
        trigger = 1'b0;
        delay   = 16'd0;
        width   = 16'd0;
        gap     = 16'd0;
        count   = 8'd0;
        repeat (3) tick();
        chk("rst_en", int'(en_out), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_idx", int'(pulse_idx), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single pulse with delay.
        arm_cfg(5, 3, 2, 1);
        fire_seq(5, 3, 2, 1, t);
        drain(60);

        // Zero fields promoted to one: three single-cycle pulses.
        arm_cfg(0, 0, 0, 3);
        fire_seq(0, 0, 0, 3, t);
        drain(60);

        // Abort during delay: nothing emitted, no done.
        arm_cfg(10, 4, 1, 2);
        trigger = 1'b1;
        t = cyc + 2;
        repeat (3) tick();
        trigger = 1'b0;
        wait_until(t + 7);
        chk("busy_in_delay", int'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_armed", int'(armed), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_en", int'(en_out), 0);
        chk("abort_idx", int'(pulse_idx), 0);
        repeat (20) tick();

        // Stale trigger level is not an edge; second edge during PULSE ignored.
        trigger = 1'b1;
        repeat (3) tick();
        trigger = 1'b0;
        repeat (3) tick();
        trigger = 1'b1;
        repeat (4) tick();
        arm_cfg(2, 3, 2, 2);
        repeat (8) tick();
        chk("held_trig_armed", int'(armed), 1);
        chk("held_trig_busy", int'(busy), 0);
        trigger = 1'b0;
        repeat (3) tick();
        trigger = 1'b1;
        t = cyc + 2;
        push_seq(t, 2, 3, 2, 2);
        wait_until(t + 1);
        trigger = 1'b0;
        wait_until(t + 3);
        trigger = 1'b1;
        drain(60);
        trigger = 1'b0;
        chk("no_auto_rearm", int'(armed), 0);
        repeat (4) tick();

        // Config changes after arm are ignored.
        arm_cfg(1, 3, 2, 3);
        delay = 16'd20;
        width = 16'd9;
        gap   = 16'd7;
        count = 8'd1;
        fire_seq(1, 3, 2, 3, t);
        drain(80);

        // arm together with abort in IDLE stays IDLE.
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        chk("arm_abort_armed", int'(armed), 0);
        chk("arm_abort_busy", int'(busy), 0);
        repeat (3) tick();

        // Asynchronous reset in the middle of a pulse.
        arm_cfg(0, 8, 1, 1);
        fire_seq(0, 8, 1, 1, t);
        wait_until(t + 3);
        chk("en_before_reset", int'(en_out), 1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_reset_en", int'(en_out), 0);
        chk("async_reset_busy", int'(busy), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_en", int'(en_out), 0);
        chk("post_reset_armed", int'(armed), 0);
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_done", int'(done), 0);
        chk("post_reset_idx", int'(pulse_idx), 0);
        repeat (2) tick();
        arm_cfg(5, 3, 2, 1);
        fire_seq(5, 3, 2, 1, t);
        drain(60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
